// File: rtl/cpc_key_scanner.sv
// Active scanner for the CPC 10x8 key matrix: drives Y, samples active-low X, debounces
// every key and emits ps2_key events. Define KEYSCAN_RELEASE_ALL_EN to release held keys when scanning stops.
module cpc_key_scanner #(
  parameter int SETTLE = 4,
  parameter int GAP    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        scan_en,
  output logic [3:0]  Y,
  input  logic [7:0]  X,
  output logic [10:0] ps2_key,
  output logic        scan_done,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DRIVE, ST_SAMPLE, ST_CHECK, ST_EMIT, ST_GAP, ST_FLUSH
  } state_t;

  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);
  localparam logic [7:0] GAP_M1    = 8'(GAP - 1);

  // Set-2 codes of one row, column 0 in the low byte.
  function automatic logic [63:0] row_codes(input logic [3:0] r);
    case (r)
      4'd0:    row_codes = 64'h7A69040B01727475;
      4'd1:    row_codes = 64'h090605030A83706B;
      4'd2:    row_codes = 64'h1461120C5D5A5B71;
      4'd3:    row_codes = 64'h494A4C524D544E55;
      4'd4:    row_codes = 64'h413A424B43444645;
      4'd5:    row_codes = 64'h29313B33353C3D3E;
      4'd6:    row_codes = 64'h2A322B342C2D2E36;
      4'd7:    row_codes = 64'h2221231B1D242625;
      4'd8:    row_codes = 64'h1A581C0D15761E16;
      4'd9:    row_codes = 64'h6600000000000000;
      default: row_codes = 64'h0;
    endcase
  endfunction

  function automatic logic [7:0] ext_mask(input logic [3:0] r);
    case (r)
      4'd0:    ext_mask = 8'hC7;
      4'd1:    ext_mask = 8'h03;
      4'd2:    ext_mask = 8'h01;
      default: ext_mask = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] valid_mask(input logic [3:0] r);
    if (r < 4'd9)       valid_mask = 8'hFF;
    else if (r == 4'd9) valid_mask = 8'h80;
    else                valid_mask = 8'h00;
  endfunction

  state_t          state;
  logic [9:0][7:0] raw_prev;
  logic [9:0][7:0] stable;
  logic [7:0]      samp;
  logic [2:0]      col;
  logic [7:0]      cnt;
  logic [9:0]      ev;
`ifdef KEYSCAN_RELEASE_ALL_EN
  logic [3:0]      frow;
  logic            flushing;
`endif

  logic [3:0]  lk_row;
  logic [63:0] lk_codes;
  logic [7:0]  lk_ext_m, lk_valid_m, lk_code;
  logic        lk_ext, lk_valid, s_c, changed, step;

  always_comb begin
    lk_row = Y;
`ifdef KEYSCAN_RELEASE_ALL_EN
    if (state == ST_FLUSH) lk_row = frow;
`endif
    lk_codes   = row_codes(lk_row);
    lk_ext_m   = ext_mask(lk_row);
    lk_valid_m = valid_mask(lk_row);
    lk_code    = lk_codes[{col, 3'b000} +: 8];
    lk_ext     = lk_ext_m[col];
    lk_valid   = lk_valid_m[col];
    s_c        = samp[col];
    // Two agreeing consecutive samples that differ from the debounced state.
    changed    = (s_c == raw_prev[Y][col]) && (s_c != stable[Y][col]);
    step       = 1'b0;
    if (state == ST_CHECK)                      step = !(changed && lk_valid);
    else if (state == ST_GAP && cnt == GAP_M1)  step = 1'b1;
`ifdef KEYSCAN_RELEASE_ALL_EN
    if (flushing) step = 1'b0;
`endif
  end

  assign state_dbg = state;

  // ps2_key[10] toggles once per event; the consumer takes ps2_key[9:0] on each toggle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      Y         <= '0;
      ps2_key   <= '0;
      scan_done <= 1'b0;
      raw_prev  <= '0;
      stable    <= '0;
      samp      <= '0;
      col       <= '0;
      cnt       <= '0;
      ev        <= '0;
`ifdef KEYSCAN_RELEASE_ALL_EN
      frow      <= '0;
      flushing  <= 1'b0;
`endif
    end else begin
      scan_done <= 1'b0;
      case (state)
        ST_IDLE: if (scan_en) begin
          state <= ST_DRIVE;
          Y     <= 4'd0;
          cnt   <= '0;
        end
        ST_DRIVE: if (cnt == SETTLE_M1) state <= ST_SAMPLE;
                  else cnt <= cnt + 8'd1;
        ST_SAMPLE: begin
          samp  <= ~X;
          col   <= '0;
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          raw_prev[Y][col] <= s_c;
          if (changed) begin
            stable[Y][col] <= s_c;
            if (lk_valid) begin
              ev    <= {s_c, lk_ext, lk_code};
              state <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          ps2_key <= {~ps2_key[10], ev};
          cnt     <= '0;
          state   <= ST_GAP;
        end
        ST_GAP: if (cnt != GAP_M1) cnt <= cnt + 8'd1;
`ifdef KEYSCAN_RELEASE_ALL_EN
        ST_FLUSH: begin
          if (stable[frow][col] && lk_valid) begin
            stable[frow][col] <= 1'b0;
            ev       <= {1'b0, lk_ext, lk_code};
            flushing <= 1'b1;
            state    <= ST_EMIT;
          end else if (col != 3'd7) begin
            col <= col + 3'd1;
          end else if (frow != 4'd9) begin
            frow <= frow + 4'd1;
            col  <= '0;
          end else begin
            stable   <= '0;
            raw_prev <= '0;
            flushing <= 1'b0;
            state    <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase

`ifdef KEYSCAN_RELEASE_ALL_EN
      if (state == ST_GAP && cnt == GAP_M1 && flushing) state <= ST_FLUSH;
`endif

      if (step) begin
        if (col != 3'd7) begin
          col   <= col + 3'd1;
          state <= ST_CHECK;
        end else begin
          if (Y == 4'd9) scan_done <= 1'b1;
          if (!scan_en) begin
`ifdef KEYSCAN_RELEASE_ALL_EN
            state <= ST_FLUSH;
            frow  <= '0;
            col   <= '0;
`else
            state <= ST_IDLE;
`endif
          end else begin
            state <= ST_DRIVE;
            Y     <= (Y == 4'd9) ? 4'd0 : Y + 4'd1;
            cnt   <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cpc_key_scanner.sv
// Bench for cpc_key_scanner: a virtual keyboard drives X from Y, and a per-scan
// key-state model predicts the ps2_key event stream and scan timing.
module tb_cpc_key_scanner;
  localparam int SETTLE  = 4;
  localparam int GAP     = 16;
  localparam int ROW_CYC = SETTLE + 9;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scan_en = 1'b0;
  logic [3:0]  Y;
  logic [7:0]  X;
  logic [10:0] ps2_key;
  logic        scan_done;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  cpc_key_scanner #(.SETTLE(SETTLE), .GAP(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .scan_en(scan_en), .Y(Y), .X(X),
    .ps2_key(ps2_key), .scan_done(scan_done), .state_dbg(state_dbg)
  );

  // Virtual keyboard: mat[r][c] = 1 means the key is held down.
  logic [7:0] mat [10];
  always_comb X = (Y < 4'd10) ? ~mat[Y] : 8'hFF;

  // Key map: 'h1xx = extended code, -1 = no code.
  int code_tbl [10][8] = '{
    '{'h175, 'h174, 'h172, 'h01, 'h0B, 'h04, 'h169, 'h17A},
    '{'h16B, 'h170, 'h83, 'h0A, 'h03, 'h05, 'h06, 'h09},
    '{'h171, 'h5B, 'h5A, 'h5D, 'h0C, 'h12, 'h61, 'h14},
    '{'h55, 'h4E, 'h54, 'h4D, 'h52, 'h4C, 'h4A, 'h49},
    '{'h45, 'h46, 'h44, 'h43, 'h4B, 'h42, 'h3A, 'h41},
    '{'h3E, 'h3D, 'h3C, 'h35, 'h33, 'h3B, 'h31, 'h29},
    '{'h36, 'h2E, 'h2D, 'h2C, 'h34, 'h2B, 'h32, 'h2A},
    '{'h25, 'h26, 'h24, 'h1D, 'h1B, 'h23, 'h21, 'h22},
    '{'h16, 'h1E, 'h76, 'h15, 'h0D, 'h1C, 'h58, 'h1A},
    '{-1, -1, -1, -1, -1, -1, -1, 'h66}
  };

  logic [7:0] m_raw [10];
  logic [7:0] m_stab [10];
  logic [9:0] exp_q [$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sd_events = 0;
  bit period_ok = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One full scan over the current keyboard: returns the number of events queued.
  function automatic int model_scan();
    int n = 0;
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 8; c++) begin
        logic s;
        s = mat[r][c];
        if (s == m_raw[r][c] && s != m_stab[r][c]) begin
          m_stab[r][c] = s;
          if (code_tbl[r][c] >= 0) begin
            exp_q.push_back({s, 9'(code_tbl[r][c])});
            n++;
          end
        end
        m_raw[r][c] = s;
      end
    end
    return n;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < 10; r++) begin
      m_raw[r]  = '0;
      m_stab[r] = '0;
      mat[r]    = '0;
    end
  endfunction

  // Compare process.
  logic [10:0] last_key = '0;
  logic [3:0]  last_y = '0;
  int          prev_sd = -1;
  int          last_tog = -1;
  always @(negedge clk) begin
    if (!reset_n) begin
      last_key = '0;
      last_y   = '0;
      prev_sd  = -1;
      last_tog = -1;
    end else begin
      if (Y !== last_y) begin
        check("y_step", 32'(Y), (last_y == 4'd9) ? 32'd0 : 32'(last_y) + 32'd1);
        last_y = Y;
      end
      if (ps2_key !== last_key) begin
        if (exp_q.size() == 0) check("unexpected_event", 32'(ps2_key), 32'(last_key));
        else check("event", 32'(ps2_key), 32'({~last_key[10], exp_q.pop_front()}));
        if (last_tog >= 0) check("event_spacing", 32'(cyc - last_tog >= GAP + 1), 32'd1);
        last_key = ps2_key;
        last_tog = cyc;
      end
      if (scan_done) begin
        check("queue_drained_at_scan_done", 32'(exp_q.size()), 32'd0);
        if (prev_sd >= 0 && period_ok)
          check("scan_period", 32'(cyc - prev_sd), 32'(10 * ROW_CYC + sd_events * (1 + GAP)));
        prev_sd = cyc;
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    scan_en = 1'b0;
    period_ok = 0;
    model_clear();
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("reset_y", 32'(Y), 32'd0);
    check("reset_ps2_key", 32'(ps2_key), 32'd0);
    check("reset_scan_done", 32'(scan_done), 32'd0);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_scan_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!scan_done && n < 3000);
    check("scan_done_seen", 32'(scan_done), 32'd1);
    #1;
  endtask

  task automatic scans(input int n);
    for (int i = 0; i < n; i++) begin
      sd_events = model_scan();
      if (!scan_en) begin
        scan_en = 1'b1;
        period_ok = 1;
      end
      wait_scan_done();
    end
  endtask

  initial begin
    model_clear();
    // Test 1: idle keyboard, three full scans.
    do_reset();
    scans(3);
    check("t1_no_events", 32'(ps2_key), 32'd0);

    // Test 2: row 4 col 2 press then release.
    do_reset();
    mat[4][2] = 1'b1;
    scans(3);
    check("t2_press", 32'(ps2_key), 32'h644);
    mat[4][2] = 1'b0;
    scans(3);
    check("t2_release", 32'(ps2_key), 32'h044);

    // Test 3: extended key row 0 col 0.
    mat[0][0] = 1'b1;
    scans(3);
    check("t3_ext_low", 32'(ps2_key[9:0]), 32'h375);
    check("t3_ext_full", 32'(ps2_key), 32'h775);

    // Test 4: one-scan glitch on row 3 col 1.
    mat[3][1] = 1'b1;
    scans(1);
    mat[3][1] = 1'b0;
    scans(2);
    check("t4_glitch_ignored", 32'(ps2_key), 32'h775);

    // Test 5: two keys in one row, reset during the gap after the first.
    do_reset();
    mat[7] = 8'b0000_1001;
    scans(1);
    sd_events = model_scan();
    begin
      int n = 0;
      while (ps2_key[7:0] !== 8'h25 && n < 600) begin
        @(negedge clk);
        n++;
      end
      check("t5_first_event_seen", 32'(n < 600), 32'd1);
    end
    check("t5_first_event", 32'(ps2_key), 32'h625);
    repeat (5) @(negedge clk);
    #1 reset_n = 1'b0;
    scan_en = 1'b0;
    period_ok = 0;
    exp_q.delete();
    model_clear();
    @(negedge clk);
    check("t5_reset_ps2_key", 32'(ps2_key), 32'd0);
    check("t5_reset_y", 32'(Y), 32'd0);
    #1 reset_n = 1'b1;
    scans(2);
    check("t5_no_late_event", 32'(ps2_key), 32'd0);

    // Random phase: sparse key toggles between scans.
    do_reset();
    for (int s = 0; s < 25; s++) begin
      if ($urandom_range(0, 3) != 0)
        for (int r = 0; r < 10; r++)
          for (int c = 0; c < 8; c++)
            if ($urandom_range(0, 39) == 0) mat[r][c] = ~mat[r][c];
      scans(1);
    end
    for (int r = 0; r < 10; r++) mat[r] = '0;
    scans(3);

    // Test 6: hold A and Z, then stop scanning during row 8.
    do_reset();
    mat[8] = 8'b1010_0000;
    scans(3);
    check("t6_held", 32'(ps2_key), 32'h21A);
    sd_events = model_scan();
    begin
      int n = 0;
      while (Y !== 4'd8 && n < 400) begin
        @(negedge clk);
        n++;
      end
      check("t6_row8_reached", 32'(n < 400), 32'd1);
    end
    #1 scan_en = 1'b0;
    period_ok = 0;
`ifdef KEYSCAN_RELEASE_ALL_EN
    exp_q.push_back(10'h01C);
    exp_q.push_back(10'h01A);
    for (int r = 0; r < 10; r++) begin
      m_raw[r]  = '0;
      m_stab[r] = '0;
    end
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("t6_flush_done", 32'(n < 2000), 32'd1);
    end
    repeat (50) @(negedge clk);
    check("t6_flush_last", 32'(ps2_key), 32'h01A);
`else
    begin
      int sd_cnt = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (scan_done) sd_cnt++;
      end
      check("t6_no_scan_done", 32'(sd_cnt), 32'd0);
    end
    check("t6_y_frozen", 32'(Y), 32'd8);
    check("t6_key_kept", 32'(ps2_key), 32'h21A);
`endif
    check("leftover_events", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
